// File: rtl/spi_ram_loader.sv
// spi_ram_loader: SPI mode-0 slave that writes (and optionally reads) a RAM port with auto-incrementing addresses.
// Readback (command 0x03) is built only when SPI_LOADER_READBACK_EN is defined.
module spi_ram_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  cmd_err
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_ADDR    = 3'd2;
  localparam logic [2:0] S_WDATA   = 3'd3;
  localparam logic [2:0] S_RDATA   = 3'd4;
  localparam logic [2:0] S_DISCARD = 3'd5;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam int SW = DATA_WIDTH > 16 ? DATA_WIDTH : 16;

  logic [2:0]            sclk_q;
  logic [1:0]            cs_s;
  logic [1:0]            mosi_s;
  logic                  cs_prev;
  logic                  rise;
  logic                  fall;
  logic                  cs_hi;
  logic [2:0]            state;
  logic [CW-1:0]         bit_cnt;
  logic [SW-2:0]         sr;
  logic [SW-1:0]         sr_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  is_rd;
  logic [CW-1:0]         obit;

  assign rise    = sclk_q[1] & ~sclk_q[2];
  assign fall    = ~sclk_q[1] & sclk_q[2];
  assign cs_hi   = cs_s[1];
  assign sr_next = {sr, mosi_s[1]};
  assign busy    = state != S_IDLE;

  // Synchronisers reset to "cs_n low" so a frame already in progress at reset release is never seen as a fresh fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q  <= '0;
      cs_s    <= '0;
      mosi_s  <= '0;
      cs_prev <= 1'b0;
    end else begin
      sclk_q  <= {sclk_q[1:0], sclk};
      cs_s    <= {cs_s[0], cs_n};
      mosi_s  <= {mosi_s[0], mosi};
      cs_prev <= cs_s[1];
    end
  end

  // Frame FSM: decodes command and address, issues single-cycle RAM accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      sr        <= '0;
      addr      <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cmd_err   <= 1'b0;
`ifdef SPI_LOADER_READBACK_EN
      is_rd     <= 1'b0;
`endif
    end else begin
      ram_en  <= 1'b0;
      ram_we  <= 1'b0;
      cmd_err <= 1'b0;
      if (state == S_IDLE) begin
        bit_cnt <= '0;
        state   <= (cs_prev & ~cs_hi) ? S_CMD : S_IDLE;
      end else if (cs_hi) begin
        state <= S_IDLE;
      end else if (rise) begin
        sr      <= sr_next[SW-2:0];
        bit_cnt <= bit_cnt + 1'b1;
        case (state)
          S_CMD: if (bit_cnt == CW'(7)) begin
            bit_cnt <= '0;
`ifdef SPI_LOADER_READBACK_EN
            is_rd   <= sr_next[7:0] == 8'h03;
            state   <= (sr_next[7:0] == 8'h02 || sr_next[7:0] == 8'h03) ? S_ADDR : S_DISCARD;
            cmd_err <= sr_next[7:0] != 8'h02 && sr_next[7:0] != 8'h03;
`else
            state   <= sr_next[7:0] == 8'h02 ? S_ADDR : S_DISCARD;
            cmd_err <= sr_next[7:0] != 8'h02;
`endif
          end
          S_ADDR: if (bit_cnt == CW'(15)) begin
            bit_cnt <= '0;
            addr    <= sr_next[ADDR_WIDTH-1:0];
            state   <= is_rd ? S_RDATA : S_WDATA;
`ifdef SPI_LOADER_READBACK_EN
            if (is_rd) begin
              ram_en   <= 1'b1;
              ram_addr <= sr_next[ADDR_WIDTH-1:0];
              addr     <= sr_next[ADDR_WIDTH-1:0] + 1'b1;
            end
`endif
          end
          S_WDATA: if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
            bit_cnt   <= '0;
            ram_en    <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= addr;
            ram_wdata <= sr_next[DATA_WIDTH-1:0];
            addr      <= addr + 1'b1;
          end
          default: ;
        endcase
`ifdef SPI_LOADER_READBACK_EN
      end else if (fall && state == S_RDATA && obit == '0) begin
        ram_en   <= 1'b1;
        ram_addr <= addr;
        addr     <= addr + 1'b1;
`endif
      end
    end
  end

`ifdef SPI_LOADER_READBACK_EN
  logic                  rd_pend;
  logic [DATA_WIDTH-1:0] pf;
  logic [DATA_WIDTH-1:0] osr;

  // Read path: capture fetched words into the prefetch buffer and shift them out on falling sclk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      pf      <= '0;
      osr     <= '0;
      obit    <= '0;
      miso    <= 1'b0;
    end else begin
      rd_pend <= ram_en & ~ram_we;
      if (rd_pend) pf <= ram_rdata;
      if (state != S_RDATA || cs_hi) begin
        obit <= '0;
        miso <= 1'b0;
      end else if (fall) begin
        miso <= obit == '0 ? pf[DATA_WIDTH-1] : osr[DATA_WIDTH-1];
        osr  <= obit == '0 ? {pf[DATA_WIDTH-2:0], 1'b0} : {osr[DATA_WIDTH-2:0], 1'b0};
        obit <= obit == '0 ? CW'(DATA_WIDTH - 1) : obit - 1'b1;
      end
    end
  end
`else
  assign is_rd = 1'b0;
  assign obit  = '0;
  assign miso  = 1'b0;
`endif
endmodule

// File: tb/tb_spi_ram_loader.sv
// tb_spi_ram_loader: directed self-checking bench for spi_ram_loader with a behavioural RAM.
module tb_spi_ram_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        ram_en;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        busy;
  logic        cmd_err;

  int n_checks = 0;
  int n_fails = 0;
  int wr_n = 0;
  int rd_n = 0;
  int err_n = 0;
  logic [7:0]  wr_a [0:63];
  logic [31:0] wr_d [0:63];
  logic [31:0] mem [0:255];
  logic [127:0] rx;
  int base;
  int rd0;
  int err0;

  spi_ram_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_wdata;
      if (wr_n < 64) begin
        wr_a[wr_n] <= ram_addr;
        wr_d[wr_n] <= ram_wdata;
      end
      wr_n <= wr_n + 1;
    end
    if (ram_en && !ram_we) begin
      ram_rdata <= mem[ram_addr];
      rd_n <= rd_n + 1;
    end
    if (cmd_err) err_n <= err_n + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer(input logic [127:0] v, input int n);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      repeat (8) @(negedge clk);
      sclk = 1'b1;
      rx = {rx[126:0], miso};
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_outputs", {miso, ram_en, ram_we, busy, cmd_err}, 5'b0);
    check("rst_addr", ram_addr, 8'h00);
    check("rst_wdata", ram_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    base = wr_n;
    cs_low();
    xfer({8'h02, 16'h0010, 32'hDEADBEEF, 32'h01234567}, 88);
    check("wr_busy", busy, 1'b1);
    cs_high();
    check("wr_count", wr_n - base, 2);
    check("wr0", {wr_a[base], wr_d[base]}, {8'h10, 32'hDEADBEEF});
    check("wr1", {wr_a[base+1], wr_d[base+1]}, {8'h11, 32'h01234567});
    check("wr_idle", {busy, ram_en, ram_we}, 3'b000);
    check("wr_hold", {ram_addr, ram_wdata}, {8'h11, 32'h01234567});

    base = wr_n;
    rd0 = rd_n;
    err0 = err_n;
    cs_low();
    xfer({8'h03, 16'h0010, 64'h0}, 88);
    cs_high();
`ifdef SPI_LOADER_READBACK_EN
    check("rd_data", rx[63:0], 64'hDEADBEEF01234567);
    check("rd_fetched", rd_n - rd0 >= 2, 1'b1);
    check("rd_no_err", err_n - err0, 0);
`else
    check("rd_disabled_err", err_n - err0, 1);
    check("rd_disabled_fetch", rd_n - rd0, 0);
    check("rd_disabled_miso", rx[63:0], 64'h0);
`endif
    check("rd_no_write", wr_n - base, 0);

    base = wr_n;
    rd0 = rd_n;
    err0 = err_n;
    cs_low();
    xfer({8'hA5, 16'h0010, 32'h12345678, 32'h9ABCDEF0}, 88);
    cs_high();
    check("bad_cmd_err", err_n - err0, 1);
    check("bad_cmd_access", (wr_n - base) + (rd_n - rd0), 0);

    base = wr_n;
    cs_low();
    xfer({8'h02, 16'h00FF, 32'h11112222, 32'h33334444}, 88);
    cs_high();
    check("wrap_count", wr_n - base, 2);
    check("wrap0", {wr_a[base], wr_d[base]}, {8'hFF, 32'h11112222});
    check("wrap1", {wr_a[base+1], wr_d[base+1]}, {8'h00, 32'h33334444});

    base = wr_n;
    cs_low();
    xfer({8'h02, 16'h0030, 20'hABCDE}, 44);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    check("partial_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    check("partial_no_write", wr_n - base, 0);
    check("partial_mem", mem[8'h30], 32'h0);

    base = wr_n;
    cs_low();
    xfer({8'h02, 16'h0020, 12'hFFF}, 36);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {miso, ram_en, ram_we, busy, cmd_err}, 5'b0);
    check("midrst_regs", {ram_addr, ram_wdata}, 40'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer({20'hFFFFF, 32'h55AA55AA}, 52);
    cs_high();
    check("midrst_no_resume", wr_n - base, 0);
    cs_low();
    xfer({8'h02, 16'h0005, 32'hCAFEF00D}, 56);
    cs_high();
    check("post_rst_count", wr_n - base, 1);
    check("post_rst_write", {wr_a[base], wr_d[base]}, {8'h05, 32'hCAFEF00D});
    check("post_rst_mem", mem[8'h05], 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/spi_ram_loader.md
# spi_ram_loader

SPI mode-0 slave that lets an external host write and read the processor's dual-port RAM through the CPU-side port (`dual_port_ram_port_if`, CPU modport), with auto-incrementing addresses. It sits upstream of the RAM and shares the RAM clock. The host uses it to load programs and data before the core runs, and to dump memory afterwards. SPI inputs are oversampled and synchronised into `clk`; `sclk` is never used as a clock.

## Interface
- `ADDR_WIDTH`, 8: RAM address width; must be ≤ 16.
- `DATA_WIDTH`, 32: RAM word width; must be a multiple of 8.
- `clk` input 1: system clock, same clock as the RAM.
- `rst_n` input 1: asynchronous, active-low reset.
- `sclk` input 1: SPI clock from the host (asynchronous).
- `cs_n` input 1: SPI chip select, active low (asynchronous).
- `mosi` input 1: host-to-loader serial data.
- `miso` output 1: loader-to-host serial data; driven 0 when idle, never tristated.
- `ram_en` output 1: RAM port enable.
- `ram_we` output 1: RAM port write enable.
- `ram_addr` output ADDR_WIDTH: RAM port address.
- `ram_wdata` output DATA_WIDTH: RAM port write data.
- `ram_rdata` input DATA_WIDTH: RAM port read data; valid 1 cycle after `ram_en`=1, `ram_we`=0.
- `busy` output 1: high while `cs_n` is low (synchronised).
- `cmd_err` output 1: 1-cycle pulse when an unsupported command byte completes.

## Operation
- `sclk`, `cs_n` and `mosi` each pass through a 2-flop synchroniser; edges are detected on the synchronised `sclk`.
- Bits are sampled on rising `sclk` and shifted MSB first; `miso` changes only on falling `sclk`.
- Frame format: command byte, then a 16-bit address (the low ADDR_WIDTH bits are used), then any number of DATA_WIDTH-bit words.
- Commands: 0x02 = write, 0x03 = read. Any other value pulses `cmd_err` and sends the FSM to DISCARD.
- FSM states: IDLE → CMD (on synchronised `cs_n` fall) → ADDR (after 8 bits) → WDATA or RDATA (after 16 bits) → DISCARD. Any state returns to IDLE on synchronised `cs_n` high.
- Write path:
  - Each completed word produces exactly one cycle of `ram_en`=`ram_we`=1 with the current address and the word.
  - The address then increments.
  - An incomplete word at `cs_n` rise is dropped; no RAM access occurs.
- Read path:
  - A fetch (`ram_en`=1, `ram_we`=0) is issued the cycle after the last address bit is sampled.
  - `ram_rdata` is captured one cycle later into a prefetch buffer and loaded into the shift register before the next falling edge.
  - When a word's MSB is loaded, the next address is prefetched.
  - Reading stops when `cs_n` rises; a trailing prefetch is harmless.
- Address increment wraps from 2^ADDR_WIDTH−1 to 0.
- `ram_en` is high only on access cycles; `ram_we` is high only on write cycles. Between accesses, `ram_addr` and `ram_wdata` hold their last values.

## Timing
- Reset values: `miso`=0, `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `busy`=0, `cmd_err`=0, FSM=IDLE, shift counters=0.
- Pin-to-detect latency: 3 `clk` cycles (2-flop synchroniser plus edge register).
- `sclk` frequency must be ≤ `clk`/8, and `cs_n` setup to the first `sclk` rise must be ≥ 4 `clk` cycles.
- Write RAM cycle: the `clk` cycle after the last bit's rising edge is detected.
- Read: the first data bit is on `miso` at the first falling edge after the address completes; the fetch-to-shift-load latency is 2 cycles.
- A rising edge detected in the same cycle as synchronised `cs_n`=1 is ignored.
- `rst_n` asserted mid-frame: all outputs go immediately to their reset values. After release, the FSM waits in IDLE for a fresh `cs_n` fall; an in-progress frame is not resumed.

## Configuration
- `SPI_LOADER_READBACK_EN` defined: command 0x03 is supported as described.
- `SPI_LOADER_READBACK_EN` undefined:
  - 0x03 is treated as invalid (`cmd_err` pulse, DISCARD).
  - `miso` is tied to 0.
  - No read or prefetch logic is built, and `ram_en` is never asserted with `ram_we`=0.

## Test plan
- Write frame 0x02, addr 0x0010, words 0xDEADBEEF, 0x01234567 → two single-cycle writes: addr 0x10 then 0x11, with the matching data.
- Read frame 0x03, addr 0x0010, 64 clocks → `miso` shifts out 0xDEADBEEF then 0x01234567, MSB first.
- Command 0xA5 → `cmd_err` pulses once, with no RAM access for the rest of the frame.
- Write at addr 0x00FF with 2 words (ADDR_WIDTH=8) → writes land at 0xFF then 0x00.
- `cs_n` raised after 20 data bits → no RAM write; FSM back in IDLE; `busy`=0 within 3 cycles.
- `rst_n` pulsed during a word → all outputs 0. A subsequent full write frame to addr 0x05 with 0xCAFEF00D writes correctly.
